// File: rtl/stage_id_pkg.sv
// Shared types and constants for the ID stage of the multithreaded pipeline.
// Optional WB-to-ID bypass is enabled by defining STAGE_ID_WB_BYPASS_EN.
package stage_id_pkg;

  localparam int unsigned N_THREADS = 4;
  localparam int unsigned N_REGS    = 32;
  localparam int unsigned XLEN      = 32;
  localparam int unsigned TID_W     = $clog2(N_THREADS);
  localparam int unsigned REGID_W   = 5;
  localparam int unsigned SB_W      = N_THREADS * N_REGS;

  typedef logic [XLEN-1:0]    word_t;
  typedef logic [XLEN-1:0]    vptr_t;
  typedef logic [TID_W-1:0]   threadid_t;
  typedef logic [REGID_W-1:0] regid_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_MUL = 2'd2
  } aluop_t;

  typedef enum logic [1:0] {
    EXC_NONE      = 2'd0,
    EXC_ITLB_MISS = 2'd1,
    EXC_ILLEGAL   = 2'd2
  } exc_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_BYTE = 3'b000;
  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;

  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_MUL = 7'b0000001;

  typedef struct packed {
    logic   legal;
    aluop_t aluop;
    word_t  imm;
    logic   use_imm;
    logic   reg_wen;
    logic   mem_ren;
    logic   mem_wen;
    logic   mem_byte;
    logic   branch;
    logic   jump;
    logic   uses_rs2;
    regid_t rd;
    regid_t rs1;
    regid_t rs2;
  } id_decoded_t;

  typedef struct packed {
    logic      valid;
    vptr_t     pc;
    threadid_t thread;
    aluop_t    aluop;
    word_t     rs1_data;
    word_t     rs2_data;
    word_t     imm;
    logic      use_imm;
    regid_t    rd;
    logic      reg_wen;
    logic      mem_ren;
    logic      mem_wen;
    logic      mem_byte;
    logic      branch;
    logic      jump;
    exc_t      exc;
  } id_ex_t;

endpackage

// File: rtl/stage_id_regfile_mt.sv
// Per-thread register file: 2 combinational read ports, 1 write port, x0 reads zero.
// With STAGE_ID_WB_BYPASS_EN a same-cycle write is forwarded to the read ports.
module regfile_mt
  import stage_id_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  threadid_t rd_thread_i,
  input  regid_t    rs1_i,
  input  regid_t    rs2_i,
  output word_t     rs1_data_c_o,
  output word_t     rs2_data_c_o,
  input  logic      we_i,
  input  threadid_t wthread_i,
  input  regid_t    wrd_i,
  input  word_t     wdata_i
);

  localparam int unsigned IDX_W = TID_W + REGID_W;

  // Flat storage indexed by {thread, reg}
  word_t mem_q [SB_W];

  logic [IDX_W-1:0] widx;
  logic [IDX_W-1:0] ridx1;
  logic [IDX_W-1:0] ridx2;

  assign widx  = {wthread_i, wrd_i};
  assign ridx1 = {rd_thread_i, rs1_i};
  assign ridx2 = {rd_thread_i, rs2_i};

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '{default: '0};
    end else if (we_i && (wrd_i != '0)) begin
      mem_q[widx] <= wdata_i;
    end
  end

  always_comb begin
    rs1_data_c_o = mem_q[ridx1];
    rs2_data_c_o = mem_q[ridx2];
`ifdef STAGE_ID_WB_BYPASS_EN
    if (we_i && (wrd_i != '0) && (widx == ridx1)) rs1_data_c_o = wdata_i;
    if (we_i && (wrd_i != '0) && (widx == ridx2)) rs2_data_c_o = wdata_i;
`endif
    if (rs1_i == '0) rs1_data_c_o = '0;
    if (rs2_i == '0) rs2_data_c_o = '0;
  end

endmodule

// File: rtl/stage_id.sv
// Decode stage: RV32 subset decode, per-thread operand read, RAW scoreboard with replay.
// Define STAGE_ID_WB_BYPASS_EN to forward same-cycle WB data and busy-clears into decode.
module stage_id
  import stage_id_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_itlb_miss,
  input  logic                 if_icache_miss,
  input  vptr_t                if_pc,
  input  word_t                if_instruction,
  input  threadid_t            if_thread,
  input  logic                 wb_en,
  input  threadid_t            wb_thread,
  input  regid_t               wb_rd,
  input  word_t                wb_data,
  output logic                 replay_en,
  output threadid_t            replay_thread,
  output vptr_t                replay_pc,
  output logic [N_THREADS-1:0] hazard_stalled,
  output logic                 ex_valid,
  output vptr_t                ex_pc,
  output threadid_t            ex_thread,
  output aluop_t               ex_aluop,
  output word_t                ex_rs1_data,
  output word_t                ex_rs2_data,
  output word_t                ex_imm,
  output logic                 ex_use_imm,
  output regid_t               ex_rd,
  output logic                 ex_reg_wen,
  output logic                 ex_mem_ren,
  output logic                 ex_mem_wen,
  output logic                 ex_mem_byte,
  output logic                 ex_branch,
  output logic                 ex_jump,
  output exc_t                 ex_exc
);

  id_decoded_t dec;
  word_t       ins;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;

  logic [SB_W-1:0]                busy_q, busy_d;
  regid_t [N_THREADS-1:0]         blk_q, blk_d;
  logic [N_THREADS-1:0]           stl_q, stl_d;
  id_ex_t                         ex_q, ex_d;

  word_t rs1_data_c, rs2_data_c;
  logic  byp1_c, byp2_c;
  logic  rs1_busy_c, rs2_busy_c;
  logic  fetch_ok_c, hazard_c, issue_c;
  logic  hz_t;

  assign ins    = if_instruction;
  assign opcode = ins[6:0];
  assign funct3 = ins[14:12];
  assign funct7 = ins[31:25];

  // Instruction decode
  always_comb begin
    dec          = '0;
    dec.aluop    = ALU_ADD;
    dec.rs1      = ins[19:15];
    dec.rs2      = ins[24:20];
    dec.rd       = ins[11:7];
    case (opcode)
      OPC_OP: begin
        dec.legal    = 1'b1;
        dec.reg_wen  = 1'b1;
        dec.uses_rs2 = 1'b1;
        case (funct7)
          F7_ADD:  dec.aluop = ALU_ADD;
          F7_SUB:  dec.aluop = ALU_SUB;
          F7_MUL:  dec.aluop = ALU_MUL;
          default: dec.legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        dec.legal   = (funct3 == F3_ADDI);
        dec.reg_wen = 1'b1;
        dec.use_imm = 1'b1;
        dec.imm     = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_LOAD: begin
        dec.legal    = (funct3 == F3_WORD) || (funct3 == F3_BYTE);
        dec.reg_wen  = 1'b1;
        dec.use_imm  = 1'b1;
        dec.mem_ren  = 1'b1;
        dec.mem_byte = (funct3 == F3_BYTE);
        dec.imm      = {{20{ins[31]}}, ins[31:20]};
      end
      OPC_STORE: begin
        dec.legal    = (funct3 == F3_WORD) || (funct3 == F3_BYTE);
        dec.use_imm  = 1'b1;
        dec.mem_wen  = 1'b1;
        dec.mem_byte = (funct3 == F3_BYTE);
        dec.uses_rs2 = 1'b1;
        dec.imm      = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OPC_BRANCH: begin
        dec.legal    = (funct3 == F3_BEQ);
        dec.branch   = 1'b1;
        dec.uses_rs2 = 1'b1;
        dec.imm      = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OPC_JAL: begin
        dec.legal   = 1'b1;
        dec.reg_wen = 1'b1;
        dec.jump    = 1'b1;
        dec.imm     = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: dec.legal = 1'b0;
    endcase
    if (!dec.reg_wen) dec.rd = '0;
  end

  regfile_mt u_regfile (
    .clk          (clk),
    .rst          (rst),
    .rd_thread_i  (if_thread),
    .rs1_i        (dec.rs1),
    .rs2_i        (dec.rs2),
    .rs1_data_c_o (rs1_data_c),
    .rs2_data_c_o (rs2_data_c),
    .we_i         (wb_en),
    .wthread_i    (wb_thread),
    .wrd_i        (wb_rd),
    .wdata_i      (wb_data)
  );

`ifdef STAGE_ID_WB_BYPASS_EN
  assign byp1_c = wb_en && (wb_thread == if_thread) && (wb_rd == dec.rs1);
  assign byp2_c = wb_en && (wb_thread == if_thread) && (wb_rd == dec.rs2);
`else
  assign byp1_c = 1'b0;
  assign byp2_c = 1'b0;
`endif

  // Hazard classification; cache/TLB faults and illegal encodings never stall
  assign rs1_busy_c = busy_q[{if_thread, dec.rs1}] & ~byp1_c;
  assign rs2_busy_c = dec.uses_rs2 & busy_q[{if_thread, dec.rs2}] & ~byp2_c;
  assign fetch_ok_c = ~if_icache_miss & ~if_itlb_miss;
  assign hazard_c   = fetch_ok_c & dec.legal & (rs1_busy_c | rs2_busy_c);
  assign issue_c    = fetch_ok_c & dec.legal & ~hazard_c;

  assign replay_en     = hazard_c & ~rst;
  assign replay_thread = if_thread;
  assign replay_pc     = if_pc;

  // Scoreboard and stall-flag next state; a same-cycle set beats a WB clear
  always_comb begin
    busy_d = busy_q;
    blk_d  = blk_q;
    stl_d  = stl_q;
    hz_t   = 1'b0;
    if (wb_en) busy_d[{wb_thread, wb_rd}] = 1'b0;
    if (issue_c && dec.reg_wen && (dec.rd != '0)) busy_d[{if_thread, dec.rd}] = 1'b1;
    for (int unsigned t = 0; t < N_THREADS; t++) begin
      hz_t = hazard_c && (if_thread == threadid_t'(t));
      if (hz_t) blk_d[threadid_t'(t)] = rs1_busy_c ? dec.rs1 : dec.rs2;
      stl_d[threadid_t'(t)] = busy_d[{threadid_t'(t), blk_d[threadid_t'(t)]}]
                              & (hz_t | stl_q[threadid_t'(t)]);
    end
  end

  // ID/EX payload
  always_comb begin
    ex_d = '0;
    if (!if_icache_miss) begin
      if (if_itlb_miss) begin
        ex_d.valid  = 1'b1;
        ex_d.pc     = if_pc;
        ex_d.thread = if_thread;
        ex_d.exc    = EXC_ITLB_MISS;
      end else if (!dec.legal) begin
        ex_d.valid  = 1'b1;
        ex_d.pc     = if_pc;
        ex_d.thread = if_thread;
        ex_d.exc    = EXC_ILLEGAL;
      end else if (issue_c) begin
        ex_d.valid    = 1'b1;
        ex_d.pc       = if_pc;
        ex_d.thread   = if_thread;
        ex_d.aluop    = dec.aluop;
        ex_d.rs1_data = rs1_data_c;
        ex_d.rs2_data = rs2_data_c;
        ex_d.imm      = dec.imm;
        ex_d.use_imm  = dec.use_imm;
        ex_d.rd       = dec.rd;
        ex_d.reg_wen  = dec.reg_wen;
        ex_d.mem_ren  = dec.mem_ren;
        ex_d.mem_wen  = dec.mem_wen;
        ex_d.mem_byte = dec.mem_byte;
        ex_d.branch   = dec.branch;
        ex_d.jump     = dec.jump;
        ex_d.exc      = EXC_NONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
      blk_q  <= '0;
      stl_q  <= '0;
      ex_q   <= '0;
    end else begin
      busy_q <= busy_d;
      blk_q  <= blk_d;
      stl_q  <= stl_d;
      ex_q   <= ex_d;
    end
  end

  assign hazard_stalled = stl_q;
  assign ex_valid       = ex_q.valid;
  assign ex_pc          = ex_q.pc;
  assign ex_thread      = ex_q.thread;
  assign ex_aluop       = ex_q.aluop;
  assign ex_rs1_data    = ex_q.rs1_data;
  assign ex_rs2_data    = ex_q.rs2_data;
  assign ex_imm         = ex_q.imm;
  assign ex_use_imm     = ex_q.use_imm;
  assign ex_rd          = ex_q.rd;
  assign ex_reg_wen     = ex_q.reg_wen;
  assign ex_mem_ren     = ex_q.mem_ren;
  assign ex_mem_wen     = ex_q.mem_wen;
  assign ex_mem_byte    = ex_q.mem_byte;
  assign ex_branch      = ex_q.branch;
  assign ex_jump        = ex_q.jump;
  assign ex_exc         = ex_q.exc;

endmodule

// File: tb/tb_stage_id.sv
// Self-checking bench for stage_id: directed scenarios plus random traffic
// compared every cycle against a behavioural model of decode, scoreboard and register file.
module tb_stage_id;
  import stage_id_pkg::*;

`ifdef STAGE_ID_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, if_itlb_miss, if_icache_miss, wb_en;
  vptr_t if_pc;
  word_t if_instruction, wb_data;
  threadid_t if_thread, wb_thread;
  regid_t wb_rd;
  logic replay_en;
  threadid_t replay_thread;
  vptr_t replay_pc;
  logic [N_THREADS-1:0] hazard_stalled;
  logic ex_valid, ex_use_imm, ex_reg_wen, ex_mem_ren, ex_mem_wen, ex_mem_byte, ex_branch, ex_jump;
  vptr_t ex_pc;
  threadid_t ex_thread;
  aluop_t ex_aluop;
  word_t ex_rs1_data, ex_rs2_data, ex_imm;
  regid_t ex_rd;
  exc_t ex_exc;

  stage_id dut (
    .clk(clk), .rst(rst), .if_itlb_miss(if_itlb_miss), .if_icache_miss(if_icache_miss),
    .if_pc(if_pc), .if_instruction(if_instruction), .if_thread(if_thread),
    .wb_en(wb_en), .wb_thread(wb_thread), .wb_rd(wb_rd), .wb_data(wb_data),
    .replay_en(replay_en), .replay_thread(replay_thread), .replay_pc(replay_pc),
    .hazard_stalled(hazard_stalled), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_thread(ex_thread),
    .ex_aluop(ex_aluop), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_use_imm(ex_use_imm), .ex_rd(ex_rd), .ex_reg_wen(ex_reg_wen), .ex_mem_ren(ex_mem_ren),
    .ex_mem_wen(ex_mem_wen), .ex_mem_byte(ex_mem_byte), .ex_branch(ex_branch), .ex_jump(ex_jump),
    .ex_exc(ex_exc)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  typedef struct {
    bit legal; int aluop; word_t imm; bit [6:0] ctrl; bit uses_rs2; int rd; int rs1; int rs2;
  } mdec_t;
  typedef struct {
    bit valid; vptr_t pc; int thread; int aluop; word_t rs1; word_t rs2; word_t imm;
    int rd; bit [6:0] ctrl; int exc;
  } mex_t;

  word_t m_regs [N_THREADS][N_REGS];
  bit    m_busy [N_THREADS][N_REGS];
  bit    m_stl  [N_THREADS];
  int    m_blk  [N_THREADS];
  bit    last_replay;
  vptr_t last_rpc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic word_t enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic word_t enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction
  function automatic word_t enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b0100011};
  endfunction
  function automatic word_t enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic word_t enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // Reference decode; ctrl = {use_imm, reg_wen, mem_ren, mem_wen, mem_byte, branch, jump}
  function automatic mdec_t mdecode(input word_t w);
    mdec_t d;
    int opc, f3, f7, off;
    opc = int'(w[6:0]); f3 = int'(w[14:12]); f7 = int'(w[31:25]);
    d = '{default: 0};
    d.rs1 = int'(w[19:15]); d.rs2 = int'(w[24:20]);
    case (opc)
      'h33: begin
        d.legal = (f7 == 0) || (f7 == 'h20) || (f7 == 1);
        d.aluop = (f7 == 0) ? 0 : (f7 == 'h20) ? 1 : 2;
        d.ctrl = 7'b0100000; d.uses_rs2 = 1;
      end
      'h13: begin
        d.legal = (f3 == 0); d.ctrl = 7'b1100000;
        d.imm = word_t'($signed(w) >>> 20);
      end
      'h03: begin
        d.legal = (f3 == 0) || (f3 == 2);
        d.ctrl = {4'b1110, bit'(f3 == 0), 2'b00};
        d.imm = word_t'($signed(w) >>> 20);
      end
      'h23: begin
        d.legal = (f3 == 0) || (f3 == 2); d.uses_rs2 = 1;
        d.ctrl = {4'b1001, bit'(f3 == 0), 2'b00};
        d.imm = (word_t'($signed(w) >>> 20) & 32'hFFFF_FFE0) | word_t'(w[11:7]);
      end
      'h63: begin
        d.legal = (f3 == 0); d.uses_rs2 = 1; d.ctrl = 7'b0000010;
        off = int'(w[31]) * 4096 + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
        if (w[31]) off = off - 8192;
        d.imm = word_t'(off);
      end
      'h6F: begin
        d.legal = 1; d.ctrl = 7'b0100001;
        off = int'(w[31]) * (1 << 20) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
        if (w[31]) off = off - (1 << 21);
        d.imm = word_t'(off);
      end
      default: d.legal = 0;
    endcase
    d.rd = d.ctrl[5] ? int'(w[11:7]) : 0;
    return d;
  endfunction

  // One cycle: apply inputs, check combinational replay, advance model, check registered outputs
  task automatic step(input bit r, input bit itlb, input bit icm, input int t, input vptr_t pc,
                      input word_t ins, input bit we, input int wt, input int wr, input word_t wd);
    mdec_t d;
    mex_t nx;
    bit hz, iss, hit1, hit2, b1, b2;
    logic [N_THREADS-1:0] sv;
    rst = r; if_itlb_miss = itlb; if_icache_miss = icm; if_thread = threadid_t'(t);
    if_pc = pc; if_instruction = ins; wb_en = we; wb_thread = threadid_t'(wt);
    wb_rd = regid_t'(wr); wb_data = wd;
    #1;
    d = mdecode(ins);
    nx = '{default: 0};
    hz = 0; iss = 0;
    hit1 = BYP && we && (wt == t) && (wr == d.rs1);
    hit2 = BYP && we && (wt == t) && (wr == d.rs2);
    b1 = m_busy[t][d.rs1] && !hit1;
    b2 = d.uses_rs2 && m_busy[t][d.rs2] && !hit2;
    if (!r && !icm) begin
      if (itlb || !d.legal) begin
        nx.valid = 1; nx.pc = pc; nx.thread = t; nx.exc = itlb ? 1 : 2;
      end else if (b1 || b2) begin
        hz = 1;
      end else begin
        iss = 1;
        nx.valid = 1; nx.pc = pc; nx.thread = t; nx.aluop = d.aluop; nx.imm = d.imm;
        nx.rd = d.rd; nx.ctrl = d.ctrl;
        nx.rs1 = (d.rs1 == 0) ? 0 : hit1 && (wr != 0) ? wd : m_regs[t][d.rs1];
        nx.rs2 = (d.rs2 == 0) ? 0 : hit2 && (wr != 0) ? wd : m_regs[t][d.rs2];
      end
    end
    chk("replay_en", 32'(replay_en), 32'(hz));
    if (hz) begin
      chk("replay_thread", 32'(replay_thread), 32'(t));
      chk("replay_pc", replay_pc, pc);
    end
    last_replay = replay_en; last_rpc = replay_pc;
    if (r) begin
      m_regs = '{default: '0}; m_busy = '{default: 0}; m_stl = '{default: 0}; m_blk = '{default: 0};
    end else begin
      if (we && wr != 0) m_regs[wt][wr] = wd;
      if (we) m_busy[wt][wr] = 0;
      if (iss && d.ctrl[5] && d.rd != 0) m_busy[t][d.rd] = 1;
      if (hz) begin m_stl[t] = 1; m_blk[t] = b1 ? d.rs1 : d.rs2; end
      for (int i = 0; i < N_THREADS; i++)
        if (m_stl[i] && !m_busy[i][m_blk[i]]) m_stl[i] = 0;
    end
    @(posedge clk); #1;
    for (int i = 0; i < N_THREADS; i++) sv[i] = m_stl[i];
    chk("ex_valid", 32'(ex_valid), 32'(nx.valid));
    chk("ex_pc", ex_pc, nx.pc);
    chk("ex_thread", 32'(ex_thread), 32'(nx.thread));
    chk("ex_aluop", 32'(ex_aluop), 32'(nx.aluop));
    chk("ex_rs1_data", ex_rs1_data, nx.rs1);
    chk("ex_rs2_data", ex_rs2_data, nx.rs2);
    chk("ex_imm", ex_imm, nx.imm);
    chk("ex_rd", 32'(ex_rd), 32'(nx.rd));
    chk("ex_ctrl", 32'({ex_use_imm, ex_reg_wen, ex_mem_ren, ex_mem_wen, ex_mem_byte, ex_branch, ex_jump}), 32'(nx.ctrl));
    chk("ex_exc", 32'(ex_exc), 32'(nx.exc));
    chk("hazard_stalled", 32'(hazard_stalled), 32'(sv));
  endtask

  task automatic idle(input bit we, input int wt, input int wr, input word_t wd);
    step(0, 0, 1, 0, 0, 0, we, wt, wr, wd);
  endtask

  function automatic word_t rnd_instr();
    logic [4:0] rd, rs1, rs2;
    logic [6:0] f7;
    int k;
    rd = 5'($urandom_range(0, 7)); rs1 = 5'($urandom_range(0, 7)); rs2 = 5'($urandom_range(0, 7));
    k = int'($urandom_range(0, 9));
    case (k)
      0, 1: begin
        f7 = ($urandom_range(0, 2) == 0) ? 7'h00 : ($urandom_range(0, 1) == 0) ? 7'h20 : 7'h01;
        return enc_r(f7, rs2, rs1, rd);
      end
      2: return enc_i(12'($urandom), rs1, 3'b000, rd, 7'b0010011);
      3: return enc_i(12'($urandom), rs1, ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b010, rd, 7'b0000011);
      4: return enc_s(12'($urandom), rs2, rs1, ($urandom_range(0, 1) == 0) ? 3'b000 : 3'b010);
      5: return enc_b(13'($urandom), rs2, rs1);
      6: return enc_j(21'($urandom), rd);
      7: return enc_i(12'($urandom), rs1, 3'($urandom), rd, 7'b0010011);
      8: return enc_r(7'($urandom), rs2, rs1, rd);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    // Reset
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("pin_reset_valid", 32'(ex_valid), 32'd0);
    chk("pin_reset_stalled", 32'(hazard_stalled), 32'd0);
    chk("pin_reset_exc", 32'(ex_exc), 32'd0);

    // ADDI x1,x0,5 on thread 0
    step(0, 0, 0, 0, 32'h100, enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'b0010011), 0, 0, 0, 0);
    chk("pin_addi_valid", 32'(ex_valid), 32'd1);
    chk("pin_addi_aluop", 32'(ex_aluop), 32'd0);
    chk("pin_addi_imm", ex_imm, 32'd5);
    chk("pin_addi_rd", 32'(ex_rd), 32'd1);
    chk("pin_addi_wen", 32'(ex_reg_wen), 32'd1);

    // ADD x2,x1,x1 on thread 0 hazards on busy x1
    step(0, 0, 0, 0, 32'h104, enc_r(7'h00, 5'd1, 5'd1, 5'd2), 0, 0, 0, 0);
    chk("pin_haz_replay", 32'(last_replay), 32'd1);
    chk("pin_haz_pc", last_rpc, 32'h104);
    chk("pin_haz_valid", 32'(ex_valid), 32'd0);
    chk("pin_haz_stalled0", 32'(hazard_stalled[0]), 32'd1);

    // Same ADD on thread 1 is independent
    step(0, 0, 0, 1, 32'h200, enc_r(7'h00, 5'd1, 5'd1, 5'd2), 0, 0, 0, 0);
    chk("pin_iso_replay", 32'(last_replay), 32'd0);
    chk("pin_iso_valid", 32'(ex_valid), 32'd1);

    // WB clears x1 on thread 0, then the replay issues with the written value
    idle(1, 0, 1, 32'd5);
    chk("pin_wb_unstall", 32'(hazard_stalled[0]), 32'd0);
    step(0, 0, 0, 0, 32'h104, enc_r(7'h00, 5'd1, 5'd1, 5'd2), 0, 0, 0, 0);
    chk("pin_replay_valid", 32'(ex_valid), 32'd1);
    chk("pin_replay_rs1", ex_rs1_data, 32'd5);
    chk("pin_replay_rs2", ex_rs2_data, 32'd5);

    // Same-cycle WB and read on thread 2 x3
    step(0, 0, 0, 2, 32'h300, enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'b0010011), 0, 0, 0, 0);
    step(0, 0, 0, 2, 32'h304, enc_r(7'h00, 5'd0, 5'd3, 5'd4), 1, 2, 3, 32'hDEADBEEF);
`ifdef STAGE_ID_WB_BYPASS_EN
    chk("pin_byp_replay", 32'(last_replay), 32'd0);
    chk("pin_byp_rs1", ex_rs1_data, 32'hDEADBEEF);
`else
    chk("pin_nobyp_replay", 32'(last_replay), 32'd1);
    chk("pin_nobyp_valid", 32'(ex_valid), 32'd0);
    step(0, 0, 0, 2, 32'h304, enc_r(7'h00, 5'd0, 5'd3, 5'd4), 0, 0, 0, 0);
    chk("pin_nobyp_rs1", ex_rs1_data, 32'hDEADBEEF);
`endif

    // I-TLB miss does not touch the scoreboard
    step(0, 1, 0, 3, 32'h400, enc_i(12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011), 0, 0, 0, 0);
    chk("pin_itlb_exc", 32'(ex_exc), 32'd1);
    chk("pin_itlb_valid", 32'(ex_valid), 32'd1);
    chk("pin_itlb_wen", 32'(ex_reg_wen), 32'd0);
    step(0, 0, 0, 3, 32'h404, enc_r(7'h00, 5'd5, 5'd5, 5'd6), 0, 0, 0, 0);
    chk("pin_itlb_nohaz", 32'(last_replay), 32'd0);

    // I-cache miss with a would-be hazard: plain bubble
    step(0, 0, 1, 0, 32'h108, enc_r(7'h00, 5'd2, 5'd2, 5'd3), 0, 0, 0, 0);
    chk("pin_icm_replay", 32'(last_replay), 32'd0);
    chk("pin_icm_valid", 32'(ex_valid), 32'd0);

    step(0, 0, 0, 1, 32'h500, 32'hFFFFFFFF, 0, 0, 0, 0);
    chk("pin_illegal_exc", 32'(ex_exc), 32'd2);

    idle(1, 1, 0, 32'h1234);
    step(0, 0, 0, 1, 32'h504, enc_r(7'h00, 5'd0, 5'd0, 5'd7), 0, 0, 0, 0);
    chk("pin_x0_rs1", ex_rs1_data, 32'd0);

    // Reset during a hazard drops the replay and the scoreboard
    step(1, 0, 0, 0, 32'h10C, enc_r(7'h00, 5'd2, 5'd2, 5'd3), 0, 0, 0, 0);
    chk("pin_rst_replay", 32'(last_replay), 32'd0);
    chk("pin_rst_stalled", 32'(hazard_stalled), 32'd0);
    step(0, 0, 0, 0, 32'h10C, enc_r(7'h00, 5'd2, 5'd2, 5'd3), 0, 0, 0, 0);
    chk("pin_rst_sbclear", 32'(last_replay), 32'd0);

    // Random traffic
    for (int c = 0; c < 800; c++) begin
      int t;
      bit we;
      t = int'($urandom_range(0, N_THREADS - 1));
      we = ($urandom_range(0, 1) == 1);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
           t, vptr_t'($urandom) & 32'hFFFF_FFFC, rnd_instr(), we,
           ($urandom_range(0, 2) == 0) ? t : int'($urandom_range(0, N_THREADS - 1)),
           int'($urandom_range(0, 7)), $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
